// File: rtl/bp_mc_pkg.sv
// rtl/bp_mc_pkg.sv - MCU bus bridge address map, status bit indices and FSM states
package bp_mc_pkg;

    localparam logic [5:0] MC_ADDR_FIFO   = 6'h00;
    localparam logic [5:0] MC_ADDR_STATUS = 6'h01;

    localparam int ST_BIT_CMD_FULL  = 0;
    localparam int ST_BIT_RSP_EMPTY = 1;
    localparam int ST_BIT_OVF       = 2;
    localparam int ST_BIT_UNF       = 3;
    localparam int ST_BIT_ERR       = 4;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR_ACT   = 2'd1,
        S_RD_FETCH = 2'd2,
        S_RD_HOLD  = 2'd3
    } mc_state_e;

endpackage

// File: rtl/mc_strobe_sync.sv
// rtl/mc_strobe_sync.sv - active-low strobe synchroniser with rise/fall detect
module mc_strobe_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic strobe_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              last_q;

    // Chain resets to the inactive (high) level so a strobe held low across reset is seen as a fresh fall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
            last_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], strobe_i};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~last_q;
    assign fall_o  = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/mc_bus_ctrl.sv
// rtl/mc_bus_ctrl.sv - MCU async bus to FIFO/register-file bridge; optional MC_CE_QUALIFY_EN gates strobes with mc_ce
module mc_bus_ctrl
    import bp_mc_pkg::*;
#(
    parameter int MC_DATA_WIDTH = 16,
    parameter int MC_ADD_WIDTH  = 6,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mc_ce,
    input  logic                     mc_we,
    input  logic                     mc_oe,
    input  logic [MC_ADD_WIDTH-1:0]  mc_add,
    input  logic [MC_DATA_WIDTH-1:0] mc_din,
    output logic [MC_DATA_WIDTH-1:0] mc_dout,
    output logic                     mc_doe,
    output logic                     cmd_push,
    output logic [MC_DATA_WIDTH-1:0] cmd_data,
    input  logic                     cmd_full,
    output logic                     rsp_pop,
    input  logic [MC_DATA_WIDTH-1:0] rsp_data,
    input  logic                     rsp_empty,
    output logic                     reg_we,
    output logic [MC_ADD_WIDTH-1:0]  reg_addr,
    output logic [MC_DATA_WIDTH-1:0] reg_wdata,
    input  logic [MC_DATA_WIDTH-1:0] reg_rdata
);
    localparam logic [MC_ADD_WIDTH-1:0] ADDR_FIFO   = MC_ADD_WIDTH'(MC_ADDR_FIFO);
    localparam logic [MC_ADD_WIDTH-1:0] ADDR_STATUS = MC_ADD_WIDTH'(MC_ADDR_STATUS);

    mc_state_e                state_q;
    logic [MC_ADD_WIDTH-1:0]  add_q;
    logic [MC_DATA_WIDTH-1:0] din_q;
    logic [MC_DATA_WIDTH-1:0] dout_q;
    logic [MC_DATA_WIDTH-1:0] cmd_data_q;
    logic [MC_DATA_WIDTH-1:0] reg_wdata_q;
    logic                     cmd_push_q;
    logic                     rsp_pop_q;
    logic                     reg_we_q;
    logic                     ovf_q;
    logic                     unf_q;
    logic                     err_q;

    logic we_s, we_rise, we_fall;
    logic oe_s, oe_rise, oe_fall;
    logic ce_act;

    mc_strobe_sync #(.STAGES(SYNC_STAGES)) u_we_sync (
        .clk_i   (clock),
        .rst_ni  (reset),
        .strobe_i(mc_we),
        .level_o (we_s),
        .rise_o  (we_rise),
        .fall_o  (we_fall)
    );

    mc_strobe_sync #(.STAGES(SYNC_STAGES)) u_oe_sync (
        .clk_i   (clock),
        .rst_ni  (reset),
        .strobe_i(mc_oe),
        .level_o (oe_s),
        .rise_o  (oe_rise),
        .fall_o  (oe_fall)
    );

`ifdef MC_CE_QUALIFY_EN
    logic ce_s, ce_rise, ce_fall;
    logic unused_edges;

    mc_strobe_sync #(.STAGES(SYNC_STAGES)) u_ce_sync (
        .clk_i   (clock),
        .rst_ni  (reset),
        .strobe_i(mc_ce),
        .level_o (ce_s),
        .rise_o  (ce_rise),
        .fall_o  (ce_fall)
    );

    assign ce_act       = ~ce_s;
    assign mc_doe       = ~mc_oe & ~mc_ce;
    assign unused_edges = we_fall ^ oe_rise ^ oe_fall ^ ce_rise ^ ce_fall;
`else
    logic unused_edges;

    assign ce_act       = 1'b1;
    assign mc_doe       = ~mc_oe;
    assign unused_edges = we_fall ^ oe_rise ^ oe_fall ^ mc_ce;
`endif

    logic                     we_low, oe_low, abort;
    logic                     ovf_set, unf_set, err_set, stat_clr;
    logic [MC_DATA_WIDTH-1:0] status;

    assign we_low = ~we_s & ce_act;
    assign oe_low = ~oe_s & ce_act;
    assign abort  = ~ce_act;

    always_comb begin
        status                    = '0;
        status[ST_BIT_CMD_FULL]   = cmd_full;
        status[ST_BIT_RSP_EMPTY]  = rsp_empty;
        status[ST_BIT_OVF]        = ovf_q;
        status[ST_BIT_UNF]        = unf_q;
        status[ST_BIT_ERR]        = err_q;
    end

    // Flag sets are OR-ed after the read-clear so an event coinciding with a status read survives it.
    assign err_set  = (state_q == S_IDLE) && we_low && oe_low;
    assign ovf_set  = (state_q == S_WR_ACT) && !abort && we_rise && (add_q == ADDR_FIFO) && cmd_full;
    assign unf_set  = (state_q == S_RD_FETCH) && !abort && (add_q == ADDR_FIFO) && rsp_empty;
    assign stat_clr = (state_q == S_RD_FETCH) && !abort && (add_q == ADDR_STATUS);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            add_q       <= '0;
            din_q       <= '0;
            dout_q      <= '0;
            cmd_data_q  <= '0;
            reg_wdata_q <= '0;
            cmd_push_q  <= 1'b0;
            rsp_pop_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            add_q      <= mc_add;
            din_q      <= mc_din;
            cmd_push_q <= 1'b0;
            rsp_pop_q  <= 1'b0;
            reg_we_q   <= 1'b0;
            ovf_q      <= ovf_set | (ovf_q & ~stat_clr);
            unf_q      <= unf_set | (unf_q & ~stat_clr);
            err_q      <= err_set | (err_q & ~stat_clr);

            case (state_q)
                S_IDLE: begin
                    if (we_low && !oe_low) begin
                        state_q <= S_WR_ACT;
                    end else if (oe_low && !we_low) begin
                        state_q <= S_RD_FETCH;
                    end
                end
                S_WR_ACT: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else if (we_rise) begin
                        state_q <= S_IDLE;
                        if (add_q == ADDR_FIFO) begin
                            if (!cmd_full) begin
                                cmd_push_q <= 1'b1;
                                cmd_data_q <= din_q;
                            end
                        end else if (add_q != ADDR_STATUS) begin
                            reg_we_q    <= 1'b1;
                            reg_wdata_q <= din_q;
                        end
                    end
                end
                S_RD_FETCH: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_RD_HOLD;
                        if (add_q == ADDR_FIFO) begin
                            if (rsp_empty) begin
                                dout_q <= '0;
                            end else begin
                                dout_q    <= rsp_data;
                                rsp_pop_q <= 1'b1;
                            end
                        end else if (add_q == ADDR_STATUS) begin
                            dout_q <= status;
                        end else begin
                            dout_q <= reg_rdata;
                        end
                    end
                end
                S_RD_HOLD: begin
                    if (oe_s || abort) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mc_dout   = dout_q;
    assign cmd_push  = cmd_push_q;
    assign cmd_data  = cmd_data_q;
    assign rsp_pop   = rsp_pop_q;
    assign reg_we    = reg_we_q;
    assign reg_addr  = add_q;
    assign reg_wdata = reg_wdata_q;

endmodule
